tc_pl_cap_data_pack: RTL and testbench

- Capture-path stage directly upstream of the ACP transmit stage.
- Accepts a free-running 32-bit sample stream for a commanded number of samples.
- Packs the samples little-endian into CAP0_15-bit words and writes them into the capture buffer FIFO that the ACP transmit stage drains.
- Signals completion once the last word, zero-padded if partial, has been written; reports dropped words caused by a full buffer.

---
 rtl/tc_pl_cap_pkg.sv | 20 ++
 rtl/tc_pl_cap_lane_pack.sv | 62 ++++++
 rtl/tc_pl_cap_data_pack.sv | 148 ++++++++++++++
 tb/tb_tc_pl_cap_data_pack.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tc_pl_cap_pkg.sv
// Types and defaults shared by the capture-path pack stage and the ACP transmit stage.
package tc_pl_cap_pkg;

    localparam int unsigned CAP0_15_DEF = 128;
    localparam int unsigned SMP_W_DEF   = 32;
    localparam int unsigned LEN_W_DEF   = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } cap_state_e;

    // Number of sample lanes in one buffer word.
    function automatic int unsigned lane_count(input int unsigned cap_w, input int unsigned smp_w);
        return cap_w / smp_w;
    endfunction

endpackage

// File: rtl/tc_pl_cap_lane_pack.sv
// Little-endian lane packer: gathers samples into one buffer word and flags word completion.
module tc_pl_cap_lane_pack
    import tc_pl_cap_pkg::*;
#(
    parameter int unsigned CAP0_15 = CAP0_15_DEF,
    parameter int unsigned SMP_W   = SMP_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic               smp_en_i,
    input  logic               last_i,
    input  logic [SMP_W-1:0]   smp_data_i,
    output logic [CAP0_15-1:0] word_c_o,
    output logic               done_c_o
);

    localparam int unsigned NL     = lane_count(CAP0_15, SMP_W);
    localparam int unsigned LANE_W = (NL > 1) ? $clog2(NL) : 1;

    logic [LANE_W-1:0]  lane_q, lane_d;
    logic [CAP0_15-1:0] pack_q, pack_d;

    // Upper lanes stay zero because the pack register is cleared at every word boundary.
    always_comb begin
        word_c_o = pack_q;
        for (int unsigned k = 0; k < NL; k++) begin
            if (lane_q == LANE_W'(k)) begin
                word_c_o[k*SMP_W +: SMP_W] = smp_data_i;
            end
        end
        done_c_o = smp_en_i & ((lane_q == LANE_W'(NL - 1)) | last_i);
    end

    always_comb begin
        lane_d = lane_q;
        pack_d = pack_q;
        if (clr_i) begin
            lane_d = '0;
            pack_d = '0;
        end else if (smp_en_i) begin
            if (done_c_o) begin
                lane_d = '0;
                pack_d = '0;
            end else begin
                lane_d = LANE_W'(lane_q + 1'b1);
                pack_d = word_c_o;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q <= '0;
            pack_q <= '0;
        end else begin
            lane_q <= lane_d;
            pack_q <= pack_d;
        end
    end

endmodule

// File: rtl/tc_pl_cap_data_pack.sv
// Capture-path pack stage: packs a sample burst into buffer words for the ACP transmit stage.
module tc_pl_cap_data_pack
    import tc_pl_cap_pkg::*;
#(
    parameter int unsigned CAP0_15 = CAP0_15_DEF,
    parameter int unsigned SMP_W   = SMP_W_DEF,
    parameter int unsigned LEN_W   = LEN_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cap_en,
    input  logic [LEN_W-1:0]   cap_len,
    output logic               cap_busy,
    output logic               cap_cmpt,
    output logic               cap_ovf,
    output logic [LEN_W-1:0]   cap_wcnt,
    input  logic               smp_valid,
    input  logic [SMP_W-1:0]   smp_data,
    input  logic               buff_full,
    output logic               buff_wr,
    output logic [CAP0_15-1:0] buff_din
);

    cap_state_e         state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   wcnt_q, wcnt_d;
    logic               busy_q, busy_d;
    logic               cmpt_q, cmpt_d;
    logic               ovf_q, ovf_d;
    logic               out_vld_q, out_vld_d;
    logic [CAP0_15-1:0] din_q, din_d;

    logic               lane_clr;
    logic               smp_en;
    logic               last_c;
    logic               word_done_c;
    logic [CAP0_15-1:0] word_c;

    tc_pl_cap_lane_pack #(
        .CAP0_15 (CAP0_15),
        .SMP_W   (SMP_W)
    ) u_lane_pack (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (lane_clr),
        .smp_en_i   (smp_en),
        .last_i     (last_c),
        .smp_data_i (smp_data),
        .word_c_o   (word_c),
        .done_c_o   (word_done_c)
    );

    assign buff_wr  = out_vld_q & ~buff_full;
    assign last_c   = (LEN_W'(cnt_q + 1'b1) == len_q);
    assign cap_busy = busy_q;
    assign cap_cmpt = cmpt_q;
    assign cap_ovf  = ovf_q;
    assign cap_wcnt = wcnt_q;
    assign buff_din = din_q;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        wcnt_d    = wcnt_q;
        busy_d    = busy_q;
        cmpt_d    = 1'b0;
        ovf_d     = ovf_q;
        out_vld_d = out_vld_q;
        din_d     = din_q;
        lane_clr  = 1'b0;
        smp_en    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cap_en) begin
                    len_d    = cap_len;
                    cnt_d    = '0;
                    wcnt_d   = '0;
                    ovf_d    = 1'b0;
                    busy_d   = 1'b1;
                    lane_clr = 1'b1;
                    state_d  = (cap_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (smp_valid) begin
                    smp_en = 1'b1;
                    cnt_d  = LEN_W'(cnt_q + 1'b1);
                    if (last_c) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!out_vld_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                cmpt_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Output register: a write frees the slot in the same cycle a new word may claim it.
        if (buff_wr) begin
            out_vld_d = 1'b0;
            wcnt_d    = LEN_W'(wcnt_d + 1'b1);
        end
        if (word_done_c) begin
            if (out_vld_q && !buff_wr) begin
                ovf_d = 1'b1;
            end else begin
                out_vld_d = 1'b1;
                din_d     = word_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            wcnt_q    <= '0;
            busy_q    <= 1'b0;
            cmpt_q    <= 1'b0;
            ovf_q     <= 1'b0;
            out_vld_q <= 1'b0;
            din_q     <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            wcnt_q    <= wcnt_d;
            busy_q    <= busy_d;
            cmpt_q    <= cmpt_d;
            ovf_q     <= ovf_d;
            out_vld_q <= out_vld_d;
            din_q     <= din_d;
        end
    end

endmodule

// File: tb/tb_tc_pl_cap_data_pack.sv
// Scoreboard bench for tc_pl_cap_data_pack: expected words/completions queued by stimulus, checked by monitor.
module tb_tc_pl_cap_data_pack;

    localparam int unsigned CW = 128;
    localparam int unsigned SW = 32;
    localparam int unsigned LW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          cap_en;
    logic [LW-1:0] cap_len;
    logic          cap_busy;
    logic          cap_cmpt;
    logic          cap_ovf;
    logic [LW-1:0] cap_wcnt;
    logic          smp_valid;
    logic [SW-1:0] smp_data;
    logic          buff_full;
    logic          buff_wr;
    logic [CW-1:0] buff_din;

    int n_chk  = 0;
    int n_pass = 0;

    logic [CW-1:0] exp_words[$];
    int            exp_wcnt[$];
    bit            exp_ovf[$];

    always #5 clk = ~clk;

    tc_pl_cap_data_pack #(
        .CAP0_15 (CW),
        .SMP_W   (SW),
        .LEN_W   (LW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cap_en    (cap_en),
        .cap_len   (cap_len),
        .cap_busy  (cap_busy),
        .cap_cmpt  (cap_cmpt),
        .cap_ovf   (cap_ovf),
        .cap_wcnt  (cap_wcnt),
        .smp_valid (smp_valid),
        .smp_data  (smp_data),
        .buff_full (buff_full),
        .buff_wr   (buff_wr),
        .buff_din  (buff_din)
    );

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [CW-1:0] w4(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] d);
        return {d, c, b, a};
    endfunction

    function automatic logic [CW-1:0] seq4(input logic [31:0] base);
        return w4(base, base + 1, base + 2, base + 3);
    endfunction

    // Monitor: every buffer write and every completion is matched against the queues.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (buff_wr === 1'b1) begin
                if (exp_words.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_wr: got write of %h expected no write", buff_din);
                end else begin
                    check("buff_din", buff_din, exp_words.pop_front());
                end
            end
            if (cap_cmpt === 1'b1) begin
                if (exp_wcnt.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_cmpt: got cap_cmpt=1 expected 0");
                end else begin
                    check("cmpt_wcnt", CW'(cap_wcnt), CW'(exp_wcnt.pop_front()));
                    check("cmpt_ovf", CW'(cap_ovf), CW'(exp_ovf.pop_front()));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cap(input int wcnt, input bit ovf);
        exp_wcnt.push_back(wcnt);
        exp_ovf.push_back(ovf);
    endtask

    task automatic start(input int len);
        cap_en  = 1'b1;
        cap_len = LW'(len);
        step();
        cap_en  = 1'b0;
        cap_len = 32'hFFFF_FFFF;
        check("busy_after_start", CW'(cap_busy), CW'(1'b1));
    endtask

    task automatic feed(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            smp_valid = 1'b1;
            smp_data  = base + 32'(i);
            step();
        end
        smp_valid = 1'b0;
        smp_data  = '0;
    endtask

    task automatic wait_cmpt(input string name);
        int k = 0;
        while (cap_cmpt !== 1'b1 && k < 200) begin
            step();
            k++;
        end
        n_chk++;
        if (cap_cmpt === 1'b1) n_pass++;
        else $display("FAIL %s_timeout: got no cap_cmpt after %0d cycles expected one", name, k);
        check({name, "_busy_low"}, CW'(cap_busy), CW'(1'b0));
        step();
    endtask

    task automatic drained(input string name);
        check({name, "_words_left"}, CW'(exp_words.size()), '0);
        check({name, "_cmpt_left"}, CW'(exp_wcnt.size()), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        cap_en    = 1'b0;
        cap_len   = '0;
        smp_valid = 1'b0;
        smp_data  = '0;
        buff_full = 1'b0;
        step();
        step();
        check("rst_busy", CW'(cap_busy), '0);
        check("rst_cmpt", CW'(cap_cmpt), '0);
        check("rst_ovf", CW'(cap_ovf), '0);
        check("rst_wcnt", CW'(cap_wcnt), '0);
        check("rst_wr", CW'(buff_wr), '0);
        check("rst_din", buff_din, '0);
        rst = 1'b0;
        step();

        // Eight samples, no backpressure: two full words.
        exp_words.push_back(seq4(32'h0));
        exp_words.push_back(seq4(32'h4));
        expect_cap(2, 1'b0);
        start(8);
        feed(32'h0, 8);
        wait_cmpt("len8");

        // Back-to-back, partial last word is zero-padded.
        exp_words.push_back(seq4(32'hA0));
        exp_words.push_back(w4(32'hA4, 32'h0, 32'h0, 32'h0));
        expect_cap(2, 1'b0);
        start(5);
        feed(32'hA0, 5);
        wait_cmpt("len5");
        drained("s2");

        // Buffer full through cycle 10: word 1 is dropped, words 0 and 2 written.
        buff_full = 1'b1;
        exp_words.push_back(seq4(32'h30));
        exp_words.push_back(seq4(32'h38));
        expect_cap(2, 1'b1);
        start(12);
        for (int i = 0; i < 12; i++) begin
            smp_valid = 1'b1;
            smp_data  = 32'h30 + 32'(i);
            buff_full = (i < 10);
            step();
        end
        smp_valid = 1'b0;
        buff_full = 1'b0;
        wait_cmpt("ovf");
        drained("s3");

        // Zero-length capture completes two cycles after cap_en.
        expect_cap(0, 1'b0);
        start(0);
        check("len0_cmpt_early", CW'(cap_cmpt), '0);
        step();
        check("len0_cmpt_at_2", CW'(cap_cmpt), CW'(1'b1));
        wait_cmpt("len0");
        drained("s4");

        // cap_en mid-capture is ignored.
        exp_words.push_back(seq4(32'h10));
        exp_words.push_back(seq4(32'h14));
        expect_cap(2, 1'b0);
        start(8);
        for (int i = 0; i < 8; i++) begin
            smp_valid = 1'b1;
            smp_data  = 32'h10 + 32'(i);
            cap_en    = (i == 2);
            cap_len   = 32'd100;
            step();
        end
        smp_valid = 1'b0;
        cap_en    = 1'b0;
        wait_cmpt("reen");
        drained("s5");

        // Reset after six of eight samples: first word already out, remainder discarded.
        exp_words.push_back(seq4(32'h50));
        start(8);
        feed(32'h50, 6);
        check("pre_rst_wcnt", CW'(cap_wcnt), CW'(1));
        rst = 1'b1;
        step();
        check("mrst_busy", CW'(cap_busy), '0);
        check("mrst_cmpt", CW'(cap_cmpt), '0);
        check("mrst_ovf", CW'(cap_ovf), '0);
        check("mrst_wcnt", CW'(cap_wcnt), '0);
        check("mrst_wr", CW'(buff_wr), '0);
        check("mrst_din", buff_din, '0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step();
        drained("s6");

        exp_words.push_back(seq4(32'h60));
        exp_words.push_back(seq4(32'h64));
        expect_cap(2, 1'b0);
        start(8);
        feed(32'h60, 8);
        wait_cmpt("post_rst");
        for (int i = 0; i < 5; i++) step();
        drained("end");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
